spi_pwm_frame_decoder: RTL and testbench

//  Upstream SPI slave front-end for the 7-channel PWM driver. Samples sclk/cs/mosi in the clk domain.

---
 rtl/spi_pwm_frame_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_spi_pwm_frame_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_frame_decoder.sv
// spi_pwm_frame_decoder
// SPI (mode 0) slave front-end for the 7-channel PWM driver. sclk, cs and mosi
// are synchronised into the clk domain. Each 16-bit MSB-first frame carries a
// command byte followed by a data byte. Writes produce a one-clock pset strobe
// with addr/level; reads shift the addressed channel level (or the device ID
// for address 7) out on miso.
// Optional feature: define SPI_DEC_PARITY_EN to require even parity over the
// full 16-bit write frame, with cmd[6] acting as the parity bit.

module spi_pwm_frame_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         NUM_CH      = 7,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       pset,
    output logic [2:0] addr,
    output logic [7:0] level,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    localparam logic [3:0] NUM_CH_W = 4'(NUM_CH);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   sclk_rise;
    logic                   sclk_fall;

    state_t                 state;
    state_t                 state_next;

    logic [14:0]            in_buf;
    logic [4:0]             bit_cnt;
    logic                   cmd_write;
    logic [2:0]             cmd_addr;
    logic [7:0]             out_buf;
    logic                   load_pend;
    logic                   overrun;

    logic [15:0]            frame_word;
    logic                   active;
    logic                   cmd_done;
    logic                   frame_done;
    logic                   addr_ok;
    logic                   parity_ok;
    logic                   do_pset;
    logic                   parity_err;
    logic                   abort_err;
    logic                   overrun_err;

    // Synchronise the SPI pins; cs starts deselected so reset never looks like a frame start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Frame bits including the one arriving on the current rise
    assign frame_word = {in_buf, mosi_s};
    assign active     = (state == CMD) || (state == DATA);
    assign cmd_done   = (state == CMD) && sclk_rise && (bit_cnt == 5'd7);
    assign frame_done = (state == DATA) && sclk_rise && (bit_cnt == 5'd15);
    assign addr_ok    = ({1'b0, cmd_addr} < NUM_CH_W);

`ifdef SPI_DEC_PARITY_EN
    assign parity_ok = ~(^frame_word);
`else
    logic unused_parity_bits;
    assign parity_ok          = 1'b1;
    assign unused_parity_bits = ^frame_word[15:8];
`endif

    // A rise coinciding with the cs rise is counted first, so a completing 16th rise is not an abort
    assign do_pset     = frame_done && cmd_write && addr_ok && parity_ok;
    assign parity_err  = frame_done && cmd_write && !parity_ok;
    assign abort_err   = cs_s && active && ((bit_cnt != 5'd0) || sclk_rise) && !frame_done;
    assign overrun_err = cs_s && (state == DONE) && (overrun || sclk_rise);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a synced cs high returns to IDLE from anywhere
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!cs_s) state_next = CMD;
            CMD: begin
                if (cs_s) state_next = IDLE;
                else if (cmd_done) state_next = DATA;
            end
            DATA: begin
                if (cs_s) state_next = IDLE;
                else if (frame_done) state_next = DONE;
            end
            DONE: if (cs_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // miso only carries the read byte during the data phase of a read frame
    always_comb begin
        miso = 1'b0;
        if ((state == DATA) && !cmd_write && !cs_s) begin
            miso = out_buf[7];
        end
    end

    // Shift-in, bit counting, command capture and read-byte shift-out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_buf    <= '0;
            bit_cnt   <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            out_buf   <= '0;
            load_pend <= 1'b0;
            overrun   <= 1'b0;
            rd_addr   <= '0;
        end else if ((state == IDLE) || cs_s) begin
            in_buf    <= '0;
            bit_cnt   <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            out_buf   <= '0;
            load_pend <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (active && sclk_rise) begin
                in_buf  <= frame_word[14:0];
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (cmd_done) begin
                cmd_write <= frame_word[7];
                cmd_addr  <= frame_word[2:0];
                if (!frame_word[7]) begin
                    rd_addr <= frame_word[2:0];
                end
            end
            load_pend <= cmd_done && !frame_word[7];
            if ((state == DONE) && sclk_rise) begin
                overrun <= 1'b1;
            end
            if (load_pend) begin
                out_buf <= (cmd_addr == 3'd7) ? ID_VALUE : rd_data;
            end else if ((state == DATA) && sclk_fall && !cmd_write &&
                         (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15)) begin
                out_buf <= {out_buf[6:0], 1'b0};
            end
        end
    end

    // One-clock write strobe with held addr/level, and the frame error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pset      <= 1'b0;
            addr      <= '0;
            level     <= '0;
            frame_err <= 1'b0;
        end else begin
            pset      <= do_pset;
            frame_err <= abort_err || overrun_err || parity_err;
            if (do_pset) begin
                addr  <= cmd_addr;
                level <= frame_word[7:0];
            end
        end
    end

endmodule

// File: tb/tb_spi_pwm_frame_decoder.sv
// tb_spi_pwm_frame_decoder
// Directed frames against a frame-level model: each frame's expected psets,
// frame errors and read byte are derived from the frame contents, then a
// monitor matches every strobe the DUT produces against those expectations.
// Honours SPI_DEC_PARITY_EN the same way the design does.

module tb_spi_pwm_frame_decoder;

    logic       clk;
    logic       reset_n;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       pset;
    logic [2:0] addr;
    logic [7:0] level;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_err;

    logic [7:0]  chan_level [0:7];
    logic [10:0] exp_pset_q [$];
    int          exp_err;
    int          tests;
    int          fails;
    logic [7:0]  got_miso;
    logic        dummy;

    spi_pwm_frame_decoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .pset      (pset),
        .addr      (addr),
        .level     (level),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_err (frame_err)
    );

    // Stand-in for the PWM block's level registers
    assign rd_data = chan_level[rd_addr];

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI bit: data set up while sclk is low, miso sampled just before the rise
    task automatic spiBit(input logic b, output logic sampled);
        mosi = b;
        waitClk(5);
        sampled = miso;
        sclk = 1'b1;
        waitClk(5);
        sclk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nbits, output logic [7:0] miso_bits);
        logic s;
        miso_bits = 8'h00;
        cs = 1'b0;
        waitClk(5);
        for (int i = 0; i < nbits; i++) begin
            spiBit((i < 16) ? word[15-i] : 1'b1, s);
            if (i >= 8 && i < 16) miso_bits[15-i] = s;
        end
        mosi = 1'b0;
        waitClk(5);
        cs = 1'b1;
        waitClk(10);
    endtask

    // Frame-level model: what a frame of this content and length must produce
    task automatic modelFrame(input logic [15:0] word, input int nbits, output logic [7:0] exp_miso);
        logic [7:0] c;
        logic       par_ok;
        c = word[15:8];
        exp_miso = 8'h00;
        if (nbits >= 16) begin
            if (c[7]) begin
                par_ok = 1'b1;
`ifdef SPI_DEC_PARITY_EN
                par_ok = ($countones(word) % 2) == 0;
`endif
                if (!par_ok) exp_err++;
                else if (c[2:0] < 3'd7) exp_pset_q.push_back({c[2:0], word[7:0]});
            end else begin
                exp_miso = (c[2:0] == 3'd7) ? 8'hA5 : chan_level[c[2:0]];
            end
            if (nbits > 16) exp_err++;
        end else if (nbits > 0) begin
            exp_err++;
        end
    endtask

    task automatic drainCheck(input string name);
        checkOutput({name, " pending psets"}, exp_pset_q.size(), 0);
        checkOutput({name, " pending frame_err"}, exp_err, 0);
        exp_pset_q.delete();
        exp_err = 0;
    endtask

    task automatic runFrame(input string name, input logic [15:0] word, input int nbits, output logic [7:0] got);
        logic [7:0] exp_m;
        modelFrame(word, nbits, exp_m);
        applyStimulus(word, nbits, got);
        if (nbits >= 16) checkOutput({name, " miso byte"}, got, exp_m);
        drainCheck(name);
    endtask

    // Match every strobe against the model's expectations
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (pset && frame_err) checkOutput("pset/frame_err overlap", 1, 0);
            if (pset) begin
                if (exp_pset_q.size() == 0) checkOutput("unexpected pset addr/level", {addr, level}, 32'hFFFF_FFFF);
                else checkOutput("pset addr/level", {addr, level}, exp_pset_q.pop_front());
            end
            if (frame_err) begin
                if (exp_err == 0) checkOutput("unexpected frame_err", 1, 0);
                else begin
                    exp_err--;
                    tests++;
                end
            end
        end
    end

    // Directed sequence
    initial begin
        tests = 0;
        fails = 0;
        exp_err = 0;
        for (int i = 0; i < 8; i++) chan_level[i] = 8'h10 + 8'(i);
        chan_level[3] = 8'h3C;
        chan_level[6] = 8'h96;
        chan_level[7] = 8'h11;
        reset_n = 1'b0;
        cs = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        waitClk(3);
        checkOutput("reset outputs", {pset, addr, level, rd_addr, frame_err, miso}, 0);
        reset_n = 1'b1;
        waitClk(5);

        runFrame("wr ch1", 16'h8180, 16, got_miso);
`ifndef SPI_DEC_PARITY_EN
        checkOutput("wr ch1 addr", addr, 1);
        checkOutput("wr ch1 level", level, 8'h80);
`endif

        runFrame("rd ch3", 16'h0300, 16, got_miso);
        checkOutput("rd ch3 literal", got_miso, 8'h3C);
        checkOutput("rd ch3 rd_addr", rd_addr, 3);

        runFrame("rd id", 16'h0700, 16, got_miso);
        checkOutput("rd id literal", got_miso, 8'hA5);
        runFrame("wr ch7 dropped", 16'h8710, 16, got_miso);
`ifndef SPI_DEC_PARITY_EN
        checkOutput("wr ch7 addr held", addr, 1);
`endif

        runFrame("wr ch6", 16'h8655, 16, got_miso);
        runFrame("rd ch6", 16'h0600, 16, got_miso);
        runFrame("rd ch0", 16'h0000, 16, got_miso);
        runFrame("empty frame", 16'h0000, 0, got_miso);

        runFrame("abort 10", 16'h8133, 10, got_miso);
        runFrame("overrun 17", 16'h8240, 17, got_miso);
`ifndef SPI_DEC_PARITY_EN
        checkOutput("overrun addr", addr, 2);
        checkOutput("overrun level", level, 8'h40);
`endif

        // Reset in the middle of a write: outputs must clear without a clock
        cs = 1'b0;
        waitClk(5);
        for (int i = 0; i < 12; i++) spiBit(((16'h8123 >> (15 - i)) & 16'h1) != 16'h0, dummy);
        waitClk(5);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset outputs", {pset, addr, level, rd_addr, frame_err, miso}, 0);
        cs = 1'b1;
        mosi = 1'b0;
        waitClk(3);
        reset_n = 1'b1;
        waitClk(10);
        drainCheck("after reset");
        runFrame("wr ch0 ff", 16'h80FF, 16, got_miso);
`ifndef SPI_DEC_PARITY_EN
        checkOutput("wr ch0 addr", addr, 0);
        checkOutput("wr ch0 level", level, 8'hFF);
`endif

`ifdef SPI_DEC_PARITY_EN
        runFrame("parity odd", 16'h8180, 16, got_miso);
        runFrame("parity even", 16'hC180, 16, got_miso);
        checkOutput("parity even addr", addr, 1);
        checkOutput("parity even level", level, 8'h80);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
